mem_lsu: RTL
============

Name: mem_lsu

Overview:
MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs and drives the data-memory request/response interface. It issues one memory transaction per load/store, stalls the upstream pipeline until the response returns, aligns/extends load data and produces the write-back bundle for the MEM/WB register. Non-memory instructions pass through with zero added latency.

Parameters:
XLEN, 64, data and address width
OFF_W, 3, byte-offset bits within an XLEN word (log2(XLEN/8))

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
flush_MEM  input  1  instruction in MEM is a bubble; no action, no write-back
rd_MEM  input  5  destination register
is_load_MEM  input  1  load instruction
is_store_MEM  input  1  store instruction
load_unsigned_MEM  input  1  zero-extend load result
wdt_op_MEM  input  4  one-hot width: [0]=byte, [1]=half, [2]=word, [3]=double
alu_result_MEM  input  XLEN  effective address, or result for non-memory ops
store_data_MEM  input  XLEN  store source (rs2), LSB-justified
req_valid  output  1  memory request valid
req_ready  input  1  memory accepts request
req_addr  output  XLEN  address, low OFF_W bits forced to 0
req_wen  output  1  1=write, 0=read
req_wdata  output  XLEN  lane-shifted store data
req_wmask  output  XLEN/8  byte-enable mask
resp_valid  input  1  read data / write ack valid (single cycle)
resp_rdata  input  XLEN  read data, full aligned word
stall_MEM  output  1  hold IF..EX/MEM registers this cycle
wb_valid  output  1  instruction retires from MEM this cycle
wb_we  output  1  register write enable
wb_rd  output  5  write-back register
wb_data  output  XLEN  write-back data
misalign  output  1  misaligned or illegal-width access, single-cycle pulse

Behaviour:
- start = ~flush_MEM & (is_load_MEM | is_store_MEM) & aligned & legal width; legal = exactly one wdt_op_MEM bit set.
- aligned: byte always; half addr[0]=0; word addr[1:0]=0; double addr[2:0]=0.
- FSM states IDLE, REQ, WAIT, DONE. Reset (async, rst=0): IDLE, all request/latch registers 0; outputs req_valid=0, stall_MEM=0, wb_valid=0, wb_we=0, misalign=0, wb_rd=0, wb_data=0, req_* =0.
- IDLE: start -> latch addr, rd, width, unsigned, wen, shifted wdata, wmask; go REQ. stall_MEM=1 same cycle.
- REQ: req_valid=1 from latched registers, stable until handshake. req_valid&req_ready -> WAIT. stall_MEM=1.
- WAIT: stall_MEM=1. resp_valid -> latch resp_rdata, go DONE.
- DONE (one cycle): stall_MEM=0, wb_valid=1, wb_rd=latched rd; load: wb_we=(rd!=0), wb_data=extended load; store: wb_we=0, wb_data=0. Next state IDLE; EX/MEM inputs are not sampled in DONE (next instruction handled in following IDLE cycle).
- IDLE, non-memory, ~flush: combinational pass-through: wb_valid=1, wb_we=(rd_MEM!=0), wb_rd=rd_MEM, wb_data=alu_result_MEM, stall_MEM=0.
- IDLE, flush_MEM=1: wb_valid=0, no request, misalign=0.
- IDLE, memory op, ~flush, misaligned or illegal width: misalign=1, wb_valid=1, wb_we=0, no request, no stall.
- Store lanes: off=addr[OFF_W-1:0]; wdata=store_data<<(8*off); wmask=widthmask<<off (byte 0x01, half 0x03, word 0x0F, double 0xFF).
- Load: raw=resp_rdata>>(8*off); truncate to width; sign-extend unless load_unsigned (double ignores unsigned).
- resp_valid outside WAIT ignored, no state change. flush_MEM only sampled in IDLE. Async reset mid-transaction: req_valid drops immediately, pending transaction abandoned.

Test Plan:
- ADD pass-through: rd=5, alu_result=0x1234, IDLE -> same cycle wb_valid=1, wb_we=1, wb_data=0x1234, stall_MEM=0.
- LB signed: addr=0x8000_0003, resp_rdata=0x0000_0000_8000_0000, req_ready same cycle as req_valid, resp_valid next -> req_addr=0x8000_0000, stall 3 cycles, DONE wb_data=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
- SH: addr=0x...06, store_data=0xBEEF -> req_wen=1, req_wmask=0xC0, req_wdata=0xBEEF<<48; DONE wb_we=0.
- Backpressure: req_ready low 4 cycles -> req_valid/addr/wdata stable, stall_MEM=1 throughout, exactly one handshake.
- LW at addr 0x...02 -> misalign=1 one cycle, req_valid=0, stall_MEM=0, wb_we=0; load with flush_MEM=1 -> no request, wb_valid=0.
- rst=0 asserted in WAIT -> req_valid/stall_MEM/wb_valid 0 immediately; stray resp_valid after release ignored, FSM stays IDLE.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one memory transaction per load/store, stalls the
// pipeline until the response returns, and forms the write-back bundle.
module mem_lsu #(
  parameter int XLEN  = 64,
  parameter int OFF_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_MEM,
  input  logic [4:0]          rd_MEM,
  input  logic                is_load_MEM,
  input  logic                is_store_MEM,
  input  logic                load_unsigned_MEM,
  input  logic [3:0]          wdt_op_MEM,
  input  logic [XLEN-1:0]     alu_result_MEM,
  input  logic [XLEN-1:0]     store_data_MEM,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [XLEN-1:0]     req_addr,
  output logic                req_wen,
  output logic [XLEN-1:0]     req_wdata,
  output logic [XLEN/8-1:0]   req_wmask,
  input  logic                resp_valid,
  input  logic [XLEN-1:0]     resp_rdata,
  output logic                stall_MEM,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                misalign
);
  localparam int BW = XLEN/8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
  logic [BW-1:0]     wmask_q;
  logic [4:0]        rd_q;
  logic [3:0]        wdt_q;
  logic              uns_q, wen_q;

  logic [OFF_W-1:0]  off_in;
  logic              mem_op, legal, aligned, start, bad;
  logic [BW-1:0]     wm_base;
  logic [XLEN-1:0]   raw, ld_ext;

  assign off_in  = alu_result_MEM[OFF_W-1:0];
  assign mem_op  = is_load_MEM | is_store_MEM;
  assign legal   = $onehot(wdt_op_MEM);
  assign aligned = wdt_op_MEM[0]
                 | (wdt_op_MEM[1] & (off_in[0]   == 1'b0))
                 | (wdt_op_MEM[2] & (off_in[1:0] == 2'b00))
                 | (wdt_op_MEM[3] & (off_in[2:0] == 3'b000));
  assign start   = ~flush_MEM & mem_op & aligned & legal;
  assign bad     = ~flush_MEM & mem_op & ~(aligned & legal);

  always_comb begin
    wm_base = BW'(8'h01);
    if (wdt_op_MEM[1]) wm_base = BW'(8'h03);
    if (wdt_op_MEM[2]) wm_base = BW'(8'h0F);
    if (wdt_op_MEM[3]) wm_base = BW'(8'hFF);
  end

  // Response word is lane-shifted down, then truncated and extended by width.
  assign raw = rdata_q >> {addr_q[OFF_W-1:0], 3'b000};
  always_comb begin
    ld_ext = raw;
    unique case (wdt_q)
      4'b0001: ld_ext = {{(XLEN-8){raw[7]   & ~uns_q}}, raw[7:0]};
      4'b0010: ld_ext = {{(XLEN-16){raw[15] & ~uns_q}}, raw[15:0]};
      4'b0100: ld_ext = {{(XLEN-32){raw[31] & ~uns_q}}, raw[31:0]};
      default: ld_ext = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wmask_q <= '0;
      rd_q    <= '0;
      wdt_q   <= '0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q  <= alu_result_MEM;
        wdata_q <= store_data_MEM << {off_in, 3'b000};
        wmask_q <= wm_base << off_in;
        rd_q    <= rd_MEM;
        wdt_q   <= wdt_op_MEM;
        uns_q   <= load_unsigned_MEM;
        wen_q   <= is_store_MEM;
      end
      if (state_q == S_WAIT && resp_valid) rdata_q <= resp_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wen   = 1'b0;
    req_wdata = '0;
    req_wmask = '0;
    stall_MEM = 1'b0;
    wb_valid  = 1'b0;
    wb_we     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    misalign  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_MEM = 1'b1;
          state_d   = S_REQ;
        end else if (bad) begin
          misalign = 1'b1;
          wb_valid = 1'b1;
          wb_rd    = rd_MEM;
        end else if (!flush_MEM) begin
          wb_valid = 1'b1;
          wb_we    = (rd_MEM != 5'd0);
          wb_rd    = rd_MEM;
          wb_data  = alu_result_MEM;
        end
      end
      S_REQ: begin
        req_valid = 1'b1;
        req_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        req_wen   = wen_q;
        req_wdata = wdata_q;
        req_wmask = wmask_q;
        stall_MEM = 1'b1;
        if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall_MEM = 1'b1;
        if (resp_valid) state_d = S_DONE;
      end
      S_DONE: begin
        wb_valid = 1'b1;
        wb_rd    = rd_q;
        if (!wen_q) begin
          wb_we   = (rd_q != 5'd0);
          wb_data = ld_ext;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are quiet for the whole reset window, not just from the next edge.
    if (!rst) begin
      req_valid = 1'b0;
      req_addr  = '0;
      req_wen   = 1'b0;
      req_wdata = '0;
      req_wmask = '0;
      stall_MEM = 1'b0;
      wb_valid  = 1'b0;
      wb_we     = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      misalign  = 1'b0;
    end
  end
endmodule
